led_breath_pwm: RTL and testbench

//  Downstream stage of the LED flow generator. Takes its 2-bit on/off pattern and drives the

---
 rtl/led_pkg.sv | 21 ++
 rtl/led_fade_chan.sv | 93 +++++++++
 rtl/led_breath_pwm.sv | 74 +++++++
 tb/tb_led_breath_pwm.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared definitions for the LED breathing PWM stage: per-channel fade state
// encoding, default timing parameters and a counter width helper.
package led_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_RISE = 2'd1,
        ST_ON   = 2'd2,
        ST_FALL = 2'd3
    } fade_state_e;

    // 50 kHz PWM at 50 MHz, 25 periods per step -> 0.5 s full fade
    localparam int unsigned DEF_PWM_STEPS = 1000;
    localparam int unsigned DEF_RAMP_DIV  = 25;

    // Bits needed to hold values 0..n-1 (at least 1)
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/led_fade_chan.sv
// One PWM fade channel: OFF/RISE/ON/FALL state machine, saturating duty
// register updated only on PWM period boundaries, and registered compare.
//   clk, rst     : clock, synchronous active-high reset
//   lvl          : registered pattern bit for this channel
//   fade_en      : 1 = fade on edges, 0 = snap at next boundary
//   boundary     : last cycle of the PWM period
//   step_tick    : boundary that also ends a ramp interval
//   pwm_cnt      : shared PWM phase counter
//   led_out      : registered PWM drive
//   fade_active  : registered, 1 while in RISE or FALL
module led_fade_chan
    import led_pkg::*;
#(
    parameter int unsigned PWM_STEPS = DEF_PWM_STEPS,
    parameter int unsigned CW        = cnt_width(DEF_PWM_STEPS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          lvl,
    input  logic          fade_en,
    input  logic          boundary,
    input  logic          step_tick,
    input  logic [CW-1:0] pwm_cnt,
    output logic          led_out,
    output logic          fade_active
);

    localparam logic [CW-1:0] DUTY_MAX = CW'(PWM_STEPS);

    fade_state_e   state_q, state_d;
    logic [CW-1:0] duty_q, duty_d;
    logic          led_out_q, led_out_d;
    logic          fade_active_q, fade_active_d;

    // Next state / duty; snap mode overrides the fade FSM entirely
    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        if (!fade_en) begin
            if (boundary) begin
                state_d = lvl ? ST_ON : ST_OFF;
                duty_d  = lvl ? DUTY_MAX : '0;
            end
        end else begin
            case (state_q)
                ST_OFF: begin
                    if (lvl) state_d = ST_RISE;
                end
                ST_RISE: begin
                    if (!lvl) begin
                        state_d = ST_FALL;
                    end else if (step_tick) begin
                        if (duty_q < DUTY_MAX) duty_d = duty_q + CW'(1);
                        if (duty_q >= DUTY_MAX - CW'(1)) state_d = ST_ON;
                    end
                end
                ST_ON: begin
                    if (!lvl) state_d = ST_FALL;
                end
                ST_FALL: begin
                    if (lvl) begin
                        state_d = ST_RISE;
                    end else if (step_tick) begin
                        if (duty_q != '0) duty_d = duty_q - CW'(1);
                        if (duty_q <= CW'(1)) state_d = ST_OFF;
                    end
                end
                default: state_d = ST_OFF;
            endcase
        end
        // pwm_cnt tops out at PWM_STEPS-1, so duty==PWM_STEPS is solid on
        led_out_d     = (pwm_cnt < duty_q);
        fade_active_d = (state_d == ST_RISE) || (state_d == ST_FALL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_OFF;
            duty_q        <= '0;
            led_out_q     <= 1'b0;
            fade_active_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            duty_q        <= duty_d;
            led_out_q     <= led_out_d;
            fade_active_q <= fade_active_d;
        end
    end

    assign led_out     = led_out_q;
    assign fade_active = fade_active_q;

endmodule

// File: rtl/led_breath_pwm.sv
// Two-channel LED breathing dimmer: fades each LED in/out on edges of the
// on/off pattern from the LED flow stage.
//   sys_clk      : system clock
//   sys_rst      : synchronous active-high reset
//   led_in[1:0]  : on/off pattern (sys_clk domain)
//   fade_en      : 1 = fade on pattern edges, 0 = snap to full/zero duty
//   led_out[1:0] : registered PWM-dimmed LED drive
//   fade_active  : per channel, 1 while rising or falling
module led_breath_pwm
    import led_pkg::*;
#(
    parameter int unsigned PWM_STEPS = DEF_PWM_STEPS,
    parameter int unsigned RAMP_DIV  = DEF_RAMP_DIV
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [1:0] led_in,
    input  logic       fade_en,
    output logic [1:0] led_out,
    output logic [1:0] fade_active
);

    // Counter wide enough to also hold the full-scale duty value
    localparam int unsigned CW = cnt_width(PWM_STEPS + 1);
    localparam int unsigned RW = cnt_width(RAMP_DIV);

    logic [1:0]    led_in_q, led_in_d;
    logic [CW-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [RW-1:0] ramp_cnt_q, ramp_cnt_d;
    logic          boundary_c;
    logic          step_tick_c;

    // Period boundary, ramp divider and shared step tick
    always_comb begin
        led_in_d    = led_in;
        boundary_c  = (pwm_cnt_q == CW'(PWM_STEPS - 1));
        step_tick_c = boundary_c && (ramp_cnt_q == RW'(RAMP_DIV - 1));
        pwm_cnt_d   = boundary_c ? '0 : pwm_cnt_q + CW'(1);
        ramp_cnt_d  = ramp_cnt_q;
        if (boundary_c) begin
            ramp_cnt_d = step_tick_c ? '0 : ramp_cnt_q + RW'(1);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            led_in_q   <= 2'b00;
            pwm_cnt_q  <= '0;
            ramp_cnt_q <= '0;
        end else begin
            led_in_q   <= led_in_d;
            pwm_cnt_q  <= pwm_cnt_d;
            ramp_cnt_q <= ramp_cnt_d;
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_chan
        led_fade_chan #(
            .PWM_STEPS (PWM_STEPS),
            .CW        (CW)
        ) u_chan (
            .clk         (sys_clk),
            .rst         (sys_rst),
            .lvl         (led_in_q[i]),
            .fade_en     (fade_en),
            .boundary    (boundary_c),
            .step_tick   (step_tick_c),
            .pwm_cnt     (pwm_cnt_q),
            .led_out     (led_out[i]),
            .fade_active (fade_active[i])
        );
    end

endmodule

// File: tb/tb_led_breath_pwm.sv
// Bench for led_breath_pwm with PWM_STEPS=4, RAMP_DIV=2.
// Cycle n = number of clock edges since the last reset edge. A PWM period p
// appears on led_out at samples n = 4p+1 .. 4p+4; step ticks land at n = 8k.
// Scoreboard entries name a sample n; the monitor compares per-period high
// counts and fade_active there.
module tb_led_breath_pwm;

    logic       sys_clk;
    logic       sys_rst;
    logic [1:0] led_in;
    logic       fade_en;
    logic [1:0] led_out;
    logic [1:0] fade_active;

    led_breath_pwm #(
        .PWM_STEPS (4),
        .RAMP_DIV  (2)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .led_in      (led_in),
        .fade_en     (fade_en),
        .led_out     (led_out),
        .fade_active (fade_active)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int         n;
        bit         chk_hi;
        int         hi0;
        int         hi1;
        logic [1:0] fa;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   rst_s    = 1'b0;
    int   acc0     = 0;
    int   acc1     = 0;

    // Edge counter relative to the last reset edge
    always @(posedge sys_clk) begin
        rst_s <= sys_rst;
        cyc   <= sys_rst ? 0 : cyc + 1;
    end

    // Monitor: reset-hold checks and scoreboard comparisons
    always @(negedge sys_clk) begin
        exp_t e;
        if (rst_s) begin
            checks++;
            if (led_out !== 2'b00 || fade_active !== 2'b00) begin
                failures++;
                $display("FAIL reset_hold: led_out=%b fade_active=%b, required 00/00",
                         led_out, fade_active);
            end
        end else if (cyc > 0) begin
            if (((cyc - 1) % 4) == 0) begin
                acc0 = (led_out[0] === 1'b1) ? 1 : 0;
                acc1 = (led_out[1] === 1'b1) ? 1 : 0;
            end else begin
                acc0 += (led_out[0] === 1'b1) ? 1 : 0;
                acc1 += (led_out[1] === 1'b1) ? 1 : 0;
            end
            while (sb.size() > 0 && sb[0].n < cyc) begin
                e = sb.pop_front();
                checks++;
                failures++;
                $display("FAIL %s: sample n=%0d passed at n=%0d without comparison",
                         e.name, e.n, cyc);
            end
            if (sb.size() > 0 && sb[0].n == cyc) begin
                e = sb.pop_front();
                checks++;
                if (fade_active !== e.fa ||
                    (e.chk_hi && (acc0 != e.hi0 || acc1 != e.hi1))) begin
                    failures++;
                    $display("FAIL %s n=%0d: hi0=%0d hi1=%0d fa=%b, required hi0=%0d hi1=%0d fa=%b",
                             e.name, cyc, acc0, acc1, fade_active,
                             e.chk_hi ? e.hi0 : acc0, e.chk_hi ? e.hi1 : acc1, e.fa);
                end
            end
        end
    end

    task automatic push(input int n, input bit chk_hi, input int hi0, input int hi1,
                        input logic [1:0] fa, input string name);
        exp_t e;
        e.n = n; e.chk_hi = chk_hi; e.hi0 = hi0; e.hi1 = hi1; e.fa = fa; e.name = name;
        sb.push_back(e);
    endtask

    // Hold reset for 'cycles' edges with the given inputs, then release
    task automatic run_reset(input int cycles, input logic [1:0] led, input logic fen);
        @(posedge sys_clk); #1;
        sys_rst = 1'b1;
        led_in  = led;
        fade_en = fen;
        repeat (cycles) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        int guard = 0;
        while (cyc != n && guard < 1000) begin
            @(posedge sys_clk); #1;
            guard++;
        end
        if (cyc != n) begin
            $display("FAIL wait_cyc: cycle %0d never reached", n);
            $fatal(1);
        end
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() > 0 && guard < 1000) begin
            @(posedge sys_clk);
            guard++;
        end
        if (sb.size() > 0) begin
            $display("FAIL drain: %0d scoreboard entries never compared", sb.size());
            $fatal(1);
        end
    endtask

    initial begin
        sys_rst = 1'b1;
        led_in  = 2'b00;
        fade_en = 1'b1;

        // Reset held 3 cycles with both inputs high, then both channels rise
        run_reset(3, 2'b11, 1'b1);
        push(1, 0, 0, 0, 2'b00, "rel_n1_still_off");
        push(2, 0, 0, 0, 2'b11, "rel_n2_rise");
        push(4, 1, 0, 0, 2'b11, "rel_p0_dark");
        drain();

        // Fade in ch0: duty 0,0,1,1,2,2,3,3,4 per period, ON from n=32
        run_reset(1, 2'b01, 1'b1);
        push(4,  1, 0, 0, 2'b01, "fin_p0");
        push(8,  1, 0, 0, 2'b01, "fin_p1");
        push(12, 1, 1, 0, 2'b01, "fin_p2_d1");
        push(16, 1, 1, 0, 2'b01, "fin_p3_d1");
        push(20, 1, 2, 0, 2'b01, "fin_p4_d2");
        push(24, 1, 2, 0, 2'b01, "fin_p5_d2");
        push(28, 1, 3, 0, 2'b01, "fin_p6_d3");
        push(32, 1, 3, 0, 2'b00, "fin_p7_on");
        push(36, 1, 4, 0, 2'b00, "fin_p8_full");
        push(40, 1, 4, 0, 2'b00, "fin_p9_full");
        drain();

        // Reversal at duty 2: falls 1, 0 with no jump, OFF at n=32
        run_reset(1, 2'b01, 1'b1);
        push(16, 1, 1, 0, 2'b01, "rev_p3_d1");
        push(20, 1, 2, 0, 2'b01, "rev_p4_hold2");
        push(24, 1, 2, 0, 2'b01, "rev_p5_hold2");
        push(28, 1, 1, 0, 2'b01, "rev_p6_d1");
        push(32, 1, 1, 0, 2'b00, "rev_p7_off");
        push(36, 1, 0, 0, 2'b00, "rev_p8_dark");
        wait_cyc(17);
        led_in = 2'b00;
        drain();

        // Snap: ch1 goes straight to full at the first boundary, no fade
        run_reset(1, 2'b10, 1'b0);
        push(2,  0, 0, 0, 2'b00, "snap_no_rise");
        push(4,  1, 0, 0, 2'b00, "snap_p0");
        push(8,  1, 0, 4, 2'b00, "snap_p1_full");
        push(12, 1, 0, 4, 2'b00, "snap_p2_full");
        drain();

        // Deassert fade_en at duty 1: snap to full at the next boundary
        run_reset(1, 2'b01, 1'b1);
        push(8,  1, 0, 0, 2'b01, "msnap_p1");
        push(12, 1, 1, 0, 2'b00, "msnap_p2_on");
        push(16, 1, 4, 0, 2'b00, "msnap_p3_full");
        wait_cyc(9);
        fade_en = 1'b0;
        drain();

        // Reset while ch0 is at duty 3: everything back to zero and OFF
        run_reset(1, 2'b01, 1'b1);
        push(24, 1, 2, 0, 2'b01, "mrst_p5_d2");
        wait_cyc(25);
        run_reset(1, 2'b00, 1'b1);
        push(4,  1, 0, 0, 2'b00, "mrst_after_p0");
        push(8,  1, 0, 0, 2'b00, "mrst_after_p1");
        push(12, 1, 0, 0, 2'b00, "mrst_after_p2");
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
